// File: rtl/qupls_rat_ckpt.sv
// Checkpointing register alias table for the Qupls rename stage.
// Optional feature macro: QUPLS_RAT_BYPASS_EN enables in-group read and wr_old bypass.
module qupls_rat_ckpt #(
   parameter int unsigned AREGS  = 64,
   parameter int unsigned PREGS  = 256,
   parameter int unsigned NCHECK = 16,
   parameter int unsigned NWR    = 4,
   parameter int unsigned NRD    = 12,
   parameter int unsigned NCMT   = 4,
   parameter int unsigned NWB    = 4,
   localparam int unsigned ABIT  = $clog2(AREGS),
   localparam int unsigned PBIT  = $clog2(PREGS),
   localparam int unsigned CBIT  = $clog2(NCHECK)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [ABIT-1:0] rd_a [NRD],
   output logic [PBIT-1:0] rd_p [NRD],
   output logic [NRD-1:0]  rd_v,
   input  logic [NWR-1:0]  wr_v,
   input  logic [ABIT-1:0] wr_a [NWR],
   input  logic [PBIT-1:0] wr_p [NWR],
   output logic [PBIT-1:0] wr_old [NWR],
   input  logic            cp_alloc,
   output logic [CBIT-1:0] cp_idx,
   output logic            cp_full,
   input  logic            cp_free,
   input  logic            restore,
   input  logic [CBIT-1:0] restore_cp,
   input  logic            flush,
   input  logic [NCMT-1:0] cmt_v,
   input  logic [ABIT-1:0] cmt_a [NCMT],
   input  logic [PBIT-1:0] cmt_p [NCMT],
   output logic [NCMT-1:0] free_v,
   output logic [PBIT-1:0] free_p [NCMT],
   input  logic [NWB-1:0]  wb_v,
   input  logic [PBIT-1:0] wb_p [NWB]
);

   localparam int unsigned CW = CBIT + 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(NCHECK);

   logic [PBIT-1:0]  cur_map [AREGS];
   logic [PBIT-1:0]  cmt_map [AREGS];
   logic [PBIT-1:0]  ckpt    [NCHECK][AREGS];
   logic [CBIT-1:0]  head, tail;
   logic [CW-1:0]    cnt;
   logic [PREGS-1:0] rdy;

   logic [NWR-1:0]   wr_en;
   logic [PBIT-1:0]  map_w   [AREGS];
   logic [PBIT-1:0]  cmt_n   [AREGS];
   logic [PBIT-1:0]  cur_n   [AREGS];
   logic [PBIT-1:0]  free_n  [NCMT];
   logic [NCMT-1:0]  fv_n;
   logic [CBIT-1:0]  head_f, head_n, tail_n, rs_cnt;
   logic [CW-1:0]    cnt_n;
   logic [PREGS-1:0] rdy_n;
   logic             do_free, do_alloc, ck_we;

   assign cp_full = (cnt == CNT_FULL);
   assign cp_idx  = tail;

   always_comb begin
      for (int s = 0; s < int'(NWR); s++)
         wr_en[s] = wr_v[s] && (wr_a[s] != '0);
   end

   // Source lookup: older same-group writes override the current map.
   always_comb begin : rd_blk
      logic [PBIT-1:0] pm;
      logic            byp;
      for (int p = 0; p < int'(NRD); p++) begin
         pm  = cur_map[rd_a[p]];
         byp = 1'b0;
`ifdef QUPLS_RAT_BYPASS_EN
         for (int s = 0; s < int'(NWR); s++) begin
            if (s < p / int'(NRD / NWR) && wr_en[s] && wr_a[s] == rd_a[p]) begin
               pm  = wr_p[s];
               byp = 1'b1;
            end
         end
`endif
         rd_v[p] = rdy[pm];
         for (int w = 0; w < int'(NWB); w++)
            if (wb_v[w] && wb_p[w] == pm) rd_v[p] = 1'b1;
         if (byp) rd_v[p] = 1'b0;
         rd_p[p] = pm;
         if (rd_a[p] == '0) begin
            rd_p[p] = '0;
            rd_v[p] = 1'b1;
         end
      end
   end

   always_comb begin
      for (int s = 0; s < int'(NWR); s++) begin
         wr_old[s] = cur_map[wr_a[s]];
`ifdef QUPLS_RAT_BYPASS_EN
         for (int t = 0; t < s; t++)
            if (wr_en[t] && wr_a[t] == wr_a[s]) wr_old[s] = wr_p[t];
`endif
      end
   end

   // Next-state: map after renames, committed map, queue pointers, ready bits.
   always_comb begin
      map_w = cur_map;
      for (int s = 0; s < int'(NWR); s++)
         if (wr_en[s]) map_w[wr_a[s]] = wr_p[s];

      cmt_n = cmt_map;
      for (int i = 0; i < int'(NCMT); i++) begin
         fv_n[i]   = cmt_v[i] && (cmt_a[i] != '0);
         free_n[i] = '0;
         if (fv_n[i]) begin
            free_n[i]        = cmt_n[cmt_a[i]];
            cmt_n[cmt_a[i]]  = cmt_p[i];
         end
      end

      do_free  = cp_free && (cnt != '0);
      do_alloc = cp_alloc && !cp_full;
      head_f   = head + CBIT'(do_free);
      rs_cnt   = restore_cp - head_f + CBIT'(1);

      rdy_n = rdy;
      for (int w = 0; w < int'(NWB); w++)
         if (wb_v[w]) rdy_n[wb_p[w]] = 1'b1;

      cur_n  = map_w;
      head_n = head_f;
      tail_n = tail + CBIT'(do_alloc);
      cnt_n  = cnt + CW'(do_alloc) - CW'(do_free);
      ck_we  = 1'b0;

      if (flush) begin
         cur_n  = cmt_n;
         head_n = '0;
         tail_n = '0;
         cnt_n  = '0;
      end else if (restore) begin
         cur_n  = ckpt[restore_cp];
         tail_n = restore_cp + CBIT'(1);
         cnt_n  = (rs_cnt == '0) ? CNT_FULL : {1'b0, rs_cnt};
      end else begin
         ck_we = do_alloc;
         // Clears applied after sets so a same-cycle rename wins over writeback.
         for (int s = 0; s < int'(NWR); s++)
            if (wr_en[s]) rdy_n[wr_p[s]] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int a = 0; a < int'(AREGS); a++) begin
            cur_map[a] <= PBIT'(a);
            cmt_map[a] <= PBIT'(a);
         end
         head   <= '0;
         tail   <= '0;
         cnt    <= '0;
         rdy    <= '1;
         free_v <= '0;
         for (int i = 0; i < int'(NCMT); i++) free_p[i] <= '0;
      end else begin
         cur_map <= cur_n;
         cmt_map <= cmt_n;
         head    <= head_n;
         tail    <= tail_n;
         cnt     <= cnt_n;
         rdy     <= rdy_n;
         free_v  <= fv_n;
         free_p  <= free_n;
      end
   end

   // Checkpoint storage needs no reset; slots are only read after being written.
   always_ff @(posedge clk) begin
      if (!rst && ck_we) ckpt[tail] <= map_w;
   end

endmodule
